// File: rtl/bitwise_gate_pipe.sv
// bitwise_gate_pipe
//   Reduces N_IN operands of WIDTH bits with a run-time selected bitwise op
//   (AND/OR/XOR/NAND/NOR/XNOR, 6-7 pass operand 0). The result and the op that
//   produced it travel through a STAGES-deep valid/ready register pipeline in
//   which bubbles collapse. Throughput is one result per cycle.
//
// Optional feature macro: GATE_ZERO_STATS_EN
//   When defined, each result carries a zero flag (out_zero). A saturating
//   16-bit counter (zero_cnt) counts output handshakes that have out_zero=1.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand bundle valid
//   in_ready   out  pipeline can accept this cycle
//   in_data    in   N_IN*WIDTH, operand k at [k*WIDTH +: WIDTH]
//   op         in   3-bit op select
//   out_valid  out  result valid
//   out_ready  in   downstream accepts
//   out_data   out  WIDTH result
//   out_op     out  op captured with the result
//   out_zero   out  (GATE_ZERO_STATS_EN) out_data == 0
//   zero_cnt   out  (GATE_ZERO_STATS_EN) saturating zero-result handshake count

// One pipeline register stage: a valid bit plus a payload. The payload only
// updates when a valid beat moves in, so idle stages do not toggle.
module gate_pipe_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          vld_in,
    input  logic [PW-1:0] pay_in,
    output logic          vld_out,
    output logic [PW-1:0] pay_out
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_out <= 1'b0;
            pay_out <= '0;
        end else if (load) begin
            vld_out <= vld_in;
            if (vld_in) pay_out <= pay_in;
        end
    end
endmodule

module bitwise_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int N_IN   = 2,
    parameter int STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [2:0]            op,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [2:0]            out_op
`ifdef GATE_ZERO_STATS_EN
    ,
    output logic                  out_zero,
    output logic [15:0]           zero_cnt
`endif
);

    // Payload layout: {[zero flag,] op, result}
`ifdef GATE_ZERO_STATS_EN
    localparam int PW = WIDTH + 4;
`else
    localparam int PW = WIDTH + 3;
`endif

    generate
        if (N_IN < 2 || N_IN > 8) begin : g_bad_nin
            $error("bitwise_gate_pipe: N_IN must be 2..8");
        end
        if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
            $error("bitwise_gate_pipe: STAGES must be 1..4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational reduction
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] red_and, red_or, red_xor, result;

    always_comb begin
        red_and = '1;
        red_or  = '0;
        red_xor = '0;
        for (int k = 0; k < N_IN; k++) begin
            red_and = red_and & in_data[k*WIDTH +: WIDTH];
            red_or  = red_or  | in_data[k*WIDTH +: WIDTH];
            red_xor = red_xor ^ in_data[k*WIDTH +: WIDTH];
        end
        case (op)
            3'd0:    result = red_and;
            3'd1:    result = red_or;
            3'd2:    result = red_xor;
            3'd3:    result = ~red_and;
            3'd4:    result = ~red_or;
            3'd5:    result = ~red_xor;
            default: result = in_data[WIDTH-1:0];
        endcase
    end

    // ------------------------------------------------------------------
    // Pipeline: index 0 is the input side, index STAGES is the output stage
    // ------------------------------------------------------------------
    logic [STAGES:0]         vld_pipe;
    logic [STAGES:0][PW-1:0] pay_pipe;
    logic [STAGES:1]         go;    // stage s hands its beat forward this cycle
    logic [STAGES:1]         load;  // stage s captures from stage s-1

    assign vld_pipe[0] = in_valid;
`ifdef GATE_ZERO_STATS_EN
    assign pay_pipe[0] = {~|result, op, result};
`else
    assign pay_pipe[0] = {op, result};
`endif

    // Ready ripples back from out_ready through the chain so a full pipe
    // that is draining can still accept a new beat in the same cycle. An
    // empty stage always loads, which is what collapses bubbles.
    always_comb begin
        go   = '0;
        load = '0;
        go[STAGES]   = vld_pipe[STAGES] & out_ready;
        load[STAGES] = ~vld_pipe[STAGES] | go[STAGES];
        for (int s = STAGES - 1; s >= 1; s--) begin
            go[s]   = vld_pipe[s] & load[s+1];
            load[s] = ~vld_pipe[s] | go[s];
        end
    end

    genvar gs;
    generate
        for (gs = 1; gs <= STAGES; gs++) begin : g_stage
            gate_pipe_stage #(.PW(PW)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (load[gs]),
                .vld_in  (vld_pipe[gs-1]),
                .pay_in  (pay_pipe[gs-1]),
                .vld_out (vld_pipe[gs]),
                .pay_out (pay_pipe[gs])
            );
        end
    endgenerate

    assign in_ready  = load[1];
    assign out_valid = vld_pipe[STAGES];
    assign out_data  = pay_pipe[STAGES][WIDTH-1:0];
    assign out_op    = pay_pipe[STAGES][WIDTH +: 3];

`ifdef GATE_ZERO_STATS_EN
    assign out_zero = pay_pipe[STAGES][PW-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt <= 16'd0;
        end else if (out_valid && out_ready && out_zero && zero_cnt != 16'hFFFF) begin
            zero_cnt <= zero_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bitwise_gate_pipe.sv
module tb_bitwise_gate_pipe;
    localparam int WIDTH  = 8;
    localparam int N_IN   = 3;
    localparam int STAGES = 2;
    localparam int DW     = N_IN * WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    op = 3'd0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic [2:0]    out_op;
`ifdef GATE_ZERO_STATS_EN
    logic          out_zero;
    logic [15:0]   zero_cnt;
`endif

    bitwise_gate_pipe #(.WIDTH(WIDTH), .N_IN(N_IN), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_op    (out_op)
`ifdef GATE_ZERO_STATS_EN
        ,
        .out_zero  (out_zero),
        .zero_cnt  (zero_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Per-bit reference: count how many operands have a 1 in that bit.
    function automatic logic [WIDTH-1:0] model_gate(input logic [DW-1:0] d, input logic [2:0] o);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            int cnt;
            cnt = 0;
            for (int k = 0; k < N_IN; k++) cnt += int'(d[k*WIDTH + b]);
            case (o)
                3'd0:    r[b] = (cnt == N_IN);
                3'd1:    r[b] = (cnt > 0);
                3'd2:    r[b] = (cnt % 2 == 1);
                3'd3:    r[b] = !(cnt == N_IN);
                3'd4:    r[b] = !(cnt > 0);
                3'd5:    r[b] = !(cnt % 2 == 1);
                default: r[b] = d[b];
            endcase
        end
        return r;
    endfunction

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [2:0]       o;
        int               t;   // earliest sample index at which it may be at the output
    } item_t;

    item_t q[$];
    int    m = 0;
    logic [WIDTH-1:0] obs_d[$];
    logic [2:0]       obs_o[$];
    int               obs_t[$];
    int               acc_t[$];
    int               zc_model = 0;

    // Compare process: the oldest accepted beat moves one stage per cycle
    // with nothing ahead of it, so it reaches the output exactly STAGES
    // samples after acceptance; in_ready is high unless the pipe holds
    // STAGES beats and the output is stalled.
    always @(negedge clk) begin
        bit exp_v;
        m++;
        if (!rst_n) begin
            q.delete();
            zc_model = 0;
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_in_ready", 32'(in_ready), 32'(1));
            check("rst_out_data", 32'(out_data), 32'(0));
            check("rst_out_op", 32'(out_op), 32'(0));
`ifdef GATE_ZERO_STATS_EN
            check("rst_zero_cnt", 32'(zero_cnt), 32'(0));
`endif
        end else begin
            check("in_ready", 32'(in_ready), 32'((q.size() < STAGES) || out_ready));
            exp_v = (q.size() > 0) && (m >= q[0].t);
            check("out_valid", 32'(out_valid), 32'(exp_v));
            if (out_valid && q.size() > 0) begin
                check("out_data", 32'(out_data), 32'(q[0].d));
                check("out_op", 32'(out_op), 32'(q[0].o));
`ifdef GATE_ZERO_STATS_EN
                check("out_zero", 32'(out_zero), 32'(q[0].d == '0));
`endif
            end
`ifdef GATE_ZERO_STATS_EN
            check("zero_cnt", 32'(zero_cnt), 32'(zc_model));
`endif
            if (out_valid && out_ready) begin
                obs_d.push_back(out_data);
                obs_o.push_back(out_op);
                obs_t.push_back(m);
                if (q.size() > 0) begin
                    if (q[0].d == '0 && zc_model < 16'hFFFF) zc_model++;
                    void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                q.push_back('{model_gate(in_data, op), op, m + STAGES});
                acc_t.push_back(m);
            end
        end
    end

    task automatic clear_logs();
        obs_d.delete();
        obs_o.delete();
        obs_t.delete();
        acc_t.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present a beat and hold it until accepted (bounded).
    task automatic send(input logic [DW-1:0] d, input logic [2:0] o, input int max_wait);
        bit acc;
        in_data  = d;
        op       = o;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < max_wait && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) check("send_timeout", 32'(0), 32'(1));
    endtask

    localparam logic [DW-1:0] D0 = {8'hF0, 8'h3C, 8'hFF};
    localparam logic [DW-1:0] DZ = {8'h0F, 8'hF0, 8'hFF};

    initial begin
        logic [WIDTH-1:0] e[3];
        logic [DW-1:0]    d3[3];

        // Reset
        out_ready = 1'b1;
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);

        // Pin the model with hand-computed values (d0=FF, d1=3C, d2=F0)
        check("pin_and",  32'(model_gate(D0, 3'd0)), 32'h30);
        check("pin_or",   32'(model_gate(D0, 3'd1)), 32'hFF);
        check("pin_xor",  32'(model_gate(D0, 3'd2)), 32'h33);
        check("pin_nand", 32'(model_gate(D0, 3'd3)), 32'hCF);
        check("pin_nor",  32'(model_gate(D0, 3'd4)), 32'h00);
        check("pin_xnor", 32'(model_gate(D0, 3'd5)), 32'hCC);
        check("pin_pass", 32'(model_gate(D0, 3'd7)), 32'hFF);

        // Single AND beat, latency STAGES
        clear_logs();
        send(D0, 3'd0, 4);
        in_valid = 1'b0;
        idle(5);
        check("t2_count", 32'(obs_d.size()), 32'(1));
        if (obs_d.size() == 1 && acc_t.size() == 1) begin
            check("t2_data", 32'(obs_d[0]), 32'h30);
            check("t2_op", 32'(obs_o[0]), 32'(0));
            check("t2_latency", 32'(obs_t[0] - acc_t[0]), 32'(STAGES));
        end

        // Back-to-back XOR, NAND, XNOR
        clear_logs();
        send(D0, 3'd2, 4);
        send(D0, 3'd3, 4);
        send(D0, 3'd5, 4);
        in_valid = 1'b0;
        idle(6);
        check("t3_count", 32'(obs_d.size()), 32'(3));
        if (obs_d.size() == 3) begin
            check("t3_xor", 32'(obs_d[0]), 32'h33);
            check("t3_nand", 32'(obs_d[1]), 32'hCF);
            check("t3_xnor", 32'(obs_d[2]), 32'hCC);
            check("t3_rate01", 32'(obs_t[1] - obs_t[0]), 32'(1));
            check("t3_rate12", 32'(obs_t[2] - obs_t[1]), 32'(1));
        end

        // Backpressure: fill, stall, then drain in order
        clear_logs();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d3[i] = DW'($urandom());
            e[i]  = model_gate(d3[i], 3'(i));
        end
        send(d3[0], 3'd0, 4);
        send(d3[1], 3'd1, 4);
        in_data = d3[2];
        op      = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_in_ready_low", 32'(in_ready), 32'(0));
            check("t4_hold_beat1", 32'(out_data), 32'(e[0]));
            @(posedge clk);
            #1;
        end
        check("t4_accepted", 32'(acc_t.size()), 32'(2));
        out_ready = 1'b1;
        send(d3[2], 3'd2, 4);
        in_valid = 1'b0;
        idle(6);
        check("t4_count", 32'(obs_d.size()), 32'(3));
        if (obs_d.size() == 3) begin
            for (int i = 0; i < 3; i++) check("t4_order", 32'(obs_d[i]), 32'(e[i]));
        end

        // Reset with two results in flight
        out_ready = 1'b0;
        send(D0, 3'd0, 4);
        send(D0, 3'd1, 4);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_out_valid", 32'(out_valid), 32'(0));
        idle(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        clear_logs();
        idle(6);
        check("t5_no_stale", 32'(obs_d.size()), 32'(0));

`ifdef GATE_ZERO_STATS_EN
        // Zero-result beats (AND of 0F, F0, FF is 00); counter starts at 0
        clear_logs();
        send(DZ, 3'd0, 4);
        send(DZ, 3'd0, 4);
        send(DZ, 3'd0, 4);
        in_valid = 1'b0;
        idle(6);
        check("t6_count", 32'(obs_d.size()), 32'(3));
        check("t6_zero_cnt", 32'(zero_cnt), 32'(3));
`else
        check("pin_zero_and", 32'(model_gate(DZ, 3'd0)), 32'h00);
`endif

        // Randomised traffic
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            in_data   = DW'($urandom());
            if ($urandom_range(7) == 0) in_data[WIDTH-1:0] = '0;
            op        = 3'($urandom());
            idle(1);
        end

        // Drain
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(10);
        check("drain_empty", 32'(q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
